// File: rtl/fpu_norm_pkg.sv
// Shared types and default widths for the significand normalization controller.
package fpu_norm_pkg;

  localparam int NORM_SW = 26;
  localparam int NORM_EW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage

// File: rtl/norm_shift_reg.sv
// Loadable left-shift register with a shift counter that saturates at SW-1.
module Norm_Shift_Reg #(
  parameter int SW = 26,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [SW-1:0] load_val,
  output logic [SW-1:0] value,
  output logic [EW-1:0] count,
  output logic          sat
);

  assign sat = (count == EW'(SW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      count <= '0;
    end else if (load) begin
      value <= load_val;
      count <= '0;
    end else if (shift) begin
      value <= value << 1;
      // Counter holds at SW-1 so an all-zero operand can never wrap it.
      if (!sat) count <= count + EW'(1);
    end
  end

endmodule

// File: rtl/norm_shift_ctrl.sv
// Normalization controller: finds the shift that puts the leading one at bit SW-2.
// Optional build macro NORM_ZERO_DETECT_EN short-cuts an all-zero operand to DONE.
module norm_shift_ctrl
  import fpu_norm_pkg::*;
#(
  parameter int SW = NORM_SW,
  parameter int EW = NORM_EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [SW-1:0] Data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          load_exp_o,
  output logic [EW-1:0] shift_amount_o,
  output logic          exp_op_mode_o,
  output logic [SW-1:0] norm_mant_o,
  output logic          zero_flag_o,
  output norm_state_t   state_dbg
);

  // Handshake: start_i is accepted only when busy_o is low (IDLE); results are
  // valid while done_o is high for one cycle and then hold until the next accept.

  norm_state_t   state, state_next;
  logic          sr_load, sr_shift, sr_sat;
  logic [SW-1:0] sr_value;
  logic [EW-1:0] sr_count;
  logic          res_en, res_mode;
  logic [EW-1:0] res_shift;
  logic [SW-1:0] res_mant;
`ifdef NORM_ZERO_DETECT_EN
  logic          res_zero, zero_q;
`endif

  Norm_Shift_Reg #(.SW(SW), .EW(EW)) u_shift_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .shift    (sr_shift),
    .load_val (Data_i),
    .value    (sr_value),
    .count    (sr_count),
    .sat      (sr_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    res_en     = 1'b0;
    res_shift  = '0;
    res_mode   = 1'b0;
    res_mant   = '0;
`ifdef NORM_ZERO_DETECT_EN
    res_zero   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_i) begin
          sr_load = 1'b1;
          if (Data_i[SW-1]) begin
            // Carry out of the adder: one right shift, exponent increments.
            state_next = DONE;
            res_en     = 1'b1;
            res_shift  = EW'(1);
            res_mode   = 1'b0;
            res_mant   = Data_i >> 1;
          end
`ifdef NORM_ZERO_DETECT_EN
          else if (Data_i == '0) begin
            state_next = DONE;
            res_en     = 1'b1;
            res_mode   = 1'b1;
            res_zero   = 1'b1;
          end
`endif
          else begin
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (sr_value[SW-2] || sr_sat) begin
          state_next = DONE;
          res_en     = 1'b1;
          res_shift  = sr_count;
          res_mode   = 1'b1;
          res_mant   = sr_value;
        end else begin
          sr_shift = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_amount_o <= '0;
      exp_op_mode_o  <= 1'b0;
      norm_mant_o    <= '0;
    end else if (res_en) begin
      shift_amount_o <= res_shift;
      exp_op_mode_o  <= res_mode;
      norm_mant_o    <= res_mant;
    end
  end

`ifdef NORM_ZERO_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         zero_q <= 1'b0;
    else if (res_en) zero_q <= res_zero;
  end
  assign zero_flag_o = zero_q;
`else
  assign zero_flag_o = 1'b0;
`endif

  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);
  assign load_exp_o = done_o;
  assign state_dbg  = state;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Self-checking bench for norm_shift_ctrl at SW=26, EW=8.
module tb_norm_shift_ctrl;
  import fpu_norm_pkg::*;

  localparam int SW = 26;
  localparam int EW = 8;

  typedef struct packed {
    logic [5:0]    lat;
    logic [EW-1:0] shift;
    logic          mode;
    logic [SW-1:0] mant;
    logic          zero;
  } exp_t;

  typedef struct {
    logic [SW-1:0] data;
    exp_t          exp;
  } vec_t;

  localparam int EXPW = $bits(exp_t);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [SW-1:0] Data_i = '0;
  logic          busy_o, done_o, load_exp_o, exp_op_mode_o, zero_flag_o;
  logic [EW-1:0] shift_amount_o;
  logic [SW-1:0] norm_mant_o;
  norm_state_t   state_dbg;

  logic [EXPW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  norm_shift_ctrl #(.SW(SW), .EW(EW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .Data_i         (Data_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .load_exp_o     (load_exp_o),
    .shift_amount_o (shift_amount_o),
    .exp_op_mode_o  (exp_op_mode_o),
    .norm_mant_o    (norm_mant_o),
    .zero_flag_o    (zero_flag_o),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int lat, input int shift, input logic mode,
                              input logic [SW-1:0] mant, input logic zero);
    exp_t e;
    e.lat = 6'(lat); e.shift = EW'(shift); e.mode = mode; e.mant = mant; e.zero = zero;
    return e;
  endfunction

  // Reference model: count leading zeros below the carry bit by walking the bits.
  function automatic exp_t model(input logic [SW-1:0] d);
    int lz;
    if (d[SW-1]) return mk(1, 1, 1'b0, d >> 1, 1'b0);
    if (d == '0) begin
`ifdef NORM_ZERO_DETECT_EN
      return mk(1, 0, 1'b1, '0, 1'b1);
`else
      return mk(SW + 1, SW - 1, 1'b1, '0, 1'b0);
`endif
    end
    lz = 0;
    for (int b = SW - 2; b >= 0; b--) begin
      if (d[b]) break;
      lz++;
    end
    return mk(lz + 2, lz, 1'b1, d << lz, 1'b0);
  endfunction

  // driver: one-cycle start pulse; the posedge after this is the start cycle's edge
  task automatic start_op(input logic [SW-1:0] d);
    @(negedge clk);
    Data_i  = d;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // monitor: waits for done_o with a cycle budget, then scoreboards against exp_q
  task automatic wait_check(input string tag, input int base);
    exp_t e;
    int   lat;
    lat = -1;
    for (int c = base + 1; c <= 60; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_t'(exp_q.pop_front());
    chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    if (lat < 0) return;
    chk({tag, " load_exp"}, 32'(load_exp_o), 32'd1);
    chk({tag, " shift"},    32'(shift_amount_o), 32'(e.shift));
    chk({tag, " mode"},     32'(exp_op_mode_o), 32'(e.mode));
    chk({tag, " mant"},     32'(norm_mant_o), 32'(e.mant));
    chk({tag, " zero"},     32'(zero_flag_o), 32'(e.zero));
    @(negedge clk);
    chk({tag, " done_pulse"}, {30'd0, done_o, busy_o}, 32'd0);
    chk({tag, " hold"},       32'(shift_amount_o), 32'(e.shift));
  endtask

  task automatic run_vec(input string tag, input logic [SW-1:0] d, input exp_t e);
    exp_q.push_back(EXPW'(e));
    start_op(d);
    wait_check(tag, 0);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done_o || busy_o) seen++;
    end
    chk({tag, " quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    // Expected vectors: constants derived by hand for SW=26.
    vecs.push_back('{26'h2000000, mk(1, 1, 1'b0, 26'h1000000, 1'b0)});
    vecs.push_back('{26'h1000000, mk(2, 0, 1'b1, 26'h1000000, 1'b0)});
    vecs.push_back('{26'h0200000, mk(5, 3, 1'b1, 26'h1000000, 1'b0)});
    vecs.push_back('{26'h3FFFFFF, mk(1, 1, 1'b0, 26'h1FFFFFF, 1'b0)});
    vecs.push_back('{26'h0800000, mk(3, 1, 1'b1, 26'h1000000, 1'b0)});
    vecs.push_back('{26'h0123456, mk(6, 4, 1'b1, 26'h1234560, 1'b0)});
    vecs.push_back('{26'h0004000, mk(12, 10, 1'b1, 26'h1000000, 1'b0)});
    vecs.push_back('{26'h0000001, mk(26, 24, 1'b1, 26'h1000000, 1'b0)});
`ifdef NORM_ZERO_DETECT_EN
    vecs.push_back('{26'h0000000, mk(1, 0, 1'b1, 26'h0000000, 1'b1)});
`else
    vecs.push_back('{26'h0000000, mk(27, 25, 1'b1, 26'h0000000, 1'b0)});
`endif

    // reset state
    repeat (2) @(negedge clk);
    chk("reset outputs", {busy_o, done_o, load_exp_o, exp_op_mode_o, zero_flag_o, 27'd0},
        32'd0);
    chk("reset shift", 32'(shift_amount_o), 32'd0);
    chk("reset mant", 32'(norm_mant_o), 32'd0);
    chk("reset state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;

    foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp);

    // random normalizable operands against the model
    for (int n = 0; n < 6; n++) begin
      logic [SW-1:0] d;
      int p;
      p = $urandom_range(0, SW - 1);
      d = (SW'(1) << p) | (SW'($urandom) & ((SW'(1) << p) - SW'(1)));
      run_vec($sformatf("rnd%0d", n), d, model(d));
    end

    // start during SCAN is ignored
    exp_q.push_back(EXPW'(mk(5, 3, 1'b1, 26'h1000000, 1'b0)));
    start_op(26'h0200000);
    @(negedge clk);
    @(negedge clk);
    Data_i  = 26'h2000000;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_check("busy_start", 2);
    check_quiet("busy_start", 6);

    // start during DONE is ignored
    exp_q.push_back(EXPW'(mk(1, 1, 1'b0, 26'h1000000, 1'b0)));
    start_op(26'h2000000);
    @(negedge clk);
    chk("done_start done", 32'(done_o), 32'd1);
    Data_i  = 26'h0200000;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    void'(exp_q.pop_front());
    check_quiet("done_start", 6);
    chk("done_start hold", 32'(shift_amount_o), 32'd1);

    // reset in the middle of a scan
    start_op(26'h0004000);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midscan outputs", {busy_o, done_o, load_exp_o, exp_op_mode_o, zero_flag_o, 27'd0},
        32'd0);
    chk("midscan shift", 32'(shift_amount_o), 32'd0);
    chk("midscan mant", 32'(norm_mant_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_quiet("midscan", 15);
    run_vec("after_reset", 26'h1000000, mk(2, 0, 1'b1, 26'h1000000, 1'b0));

    chk("queue empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
